// File: rtl/modn_counter_pkg.sv
// Shared types and step arithmetic for the modulo-N counter family.
// Used by modn_counter; see that file for the MODN_COUNTER_PRESCALE_EN option.
package modn_counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  localparam int unsigned CALC_W = 32;

  typedef struct packed {
    logic [CALC_W-1:0] value;
    logic              wrapped;
  } step_t;

  // The wrap compare happens on the current value, so MODULUS == 2**WIDTH never overflows.
  function automatic step_t next_count(input logic [CALC_W-1:0] cur,
                                       input dir_e              dir,
                                       input logic [CALC_W-1:0] modulus);
    step_t s;
    s.value   = cur;
    s.wrapped = 1'b0;
    if (dir == DIR_UP) begin
      if (cur == modulus - 32'd1) begin
        s.value   = '0;
        s.wrapped = 1'b1;
      end else begin
        s.value = cur + 32'd1;
      end
    end else begin
      if (cur == '0) begin
        s.value   = modulus - 32'd1;
        s.wrapped = 1'b1;
      end else begin
        s.value = cur - 32'd1;
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/modn_prescaler.sv
// Enable prescaler: tick fires on every (div+1)-th enabled cycle.
// Only instantiated by modn_counter when MODN_COUNTER_PRESCALE_EN is defined.
module modn_prescaler #(
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] div,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] presc;

  assign tick = en & (presc == div);

  // Lowering div below the current presc lets presc run on and wrap through zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if (clr) begin
      presc <= '0;
    end else if (en) begin
      if (presc == div) begin
        presc <= '0;
      end else begin
        presc <= presc + PRESCALE_W'(1);
      end
    end
  end

endmodule

// File: rtl/modn_counter.sv
// Parametrised modulo-N up/down counter with clear, load, tc lookahead and wrap/load_err pulses.
// Optional enable prescaler and presc_div port when MODN_COUNTER_PRESCALE_EN is defined.
module modn_counter
  import modn_counter_pkg::*;
#(
  parameter int WIDTH      = 3,
  parameter int MODULUS    = 6,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  clr,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
`ifdef MODN_COUNTER_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] presc_div,
`endif
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  wrap,
  output logic                  load_err
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  if (MODULUS < 2) begin : g_bad_modulus
    $error("modn_counter: MODULUS must be at least 2");
  end
  if (WIDTH < 1 || WIDTH >= 31 || (longint'(1) << WIDTH) < longint'(MODULUS)) begin : g_bad_width
    $error("modn_counter: WIDTH too small for MODULUS or out of range");
  end
  if (PRESCALE_W < 1) begin : g_bad_prescale
    $error("modn_counter: PRESCALE_W must be at least 1");
  end

  logic   en_eff;
  logic   at_terminal;
  logic   load_in_range;
  step_t  step;
  logic [CALC_W-1:WIDTH] unused_step_hi;

`ifdef MODN_COUNTER_PRESCALE_EN
  // Clear and load both restart the prescale phase.
  modn_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .clr  (clr | load),
    .div  (presc_div),
    .tick (en_eff)
  );
`else
  assign en_eff = en;
`endif

  assign step           = next_count(CALC_W'(count), dir_e'(up_dn), CALC_W'(MODULUS));
  assign unused_step_hi = step.value[CALC_W-1:WIDTH];
  assign at_terminal    = up_dn ? (count == LAST) : (count == '0);
  assign tc             = en_eff & ~clr & ~load & at_terminal;
  assign load_in_range  = ({1'b0, load_val} < (WIDTH + 1)'(MODULUS));

  // Priority is clr > load > step > hold; the pulse outputs default low every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      wrap     <= 1'b0;
      load_err <= 1'b0;
      if (clr) begin
        count <= '0;
      end else if (load) begin
        if (load_in_range) begin
          count <= load_val;
        end else begin
          count    <= LAST;
          load_err <= 1'b1;
        end
      end else if (en_eff) begin
        count <= step.value[WIDTH-1:0];
        wrap  <= step.wrapped;
      end
    end
  end

endmodule

// File: tb/tb_modn_counter.sv
// Directed self-checking bench for modn_counter (mod-6, mod-8 boundary and a 6x10 cascade).
// Prescaler scenario runs only when MODN_COUNTER_PRESCALE_EN is defined.
module tb_modn_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, up_dn, clr, load;
  logic [2:0] load_val;
  logic [2:0] count;
  logic       tc, wrap, load_err;

  logic       en8, up8;
  logic [2:0] count8;
  logic       tc8, wrap8, load_err8;

  logic       c6_en;
  logic [2:0] c6_count;
  logic       c6_tc, c6_wrap, c6_err;
  logic [3:0] c10_count;
  logic       c10_tc, c10_wrap, c10_err;

`ifdef MODN_COUNTER_PRESCALE_EN
  logic [3:0] presc_div;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  modn_counter #(.WIDTH(3), .MODULUS(6), .PRESCALE_W(4)) dut (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val),
`ifdef MODN_COUNTER_PRESCALE_EN
    .presc_div(presc_div),
`endif
    .count(count), .tc(tc), .wrap(wrap), .load_err(load_err)
  );

  modn_counter #(.WIDTH(3), .MODULUS(8), .PRESCALE_W(4)) dut8 (
    .clk(clk), .reset(reset), .en(en8), .up_dn(up8), .clr(1'b0), .load(1'b0),
    .load_val(3'd0),
`ifdef MODN_COUNTER_PRESCALE_EN
    .presc_div(4'd0),
`endif
    .count(count8), .tc(tc8), .wrap(wrap8), .load_err(load_err8)
  );

  modn_counter #(.WIDTH(3), .MODULUS(6), .PRESCALE_W(4)) stage6 (
    .clk(clk), .reset(reset), .en(c6_en), .up_dn(1'b1), .clr(1'b0), .load(1'b0),
    .load_val(3'd0),
`ifdef MODN_COUNTER_PRESCALE_EN
    .presc_div(4'd0),
`endif
    .count(c6_count), .tc(c6_tc), .wrap(c6_wrap), .load_err(c6_err)
  );

  modn_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE_W(4)) stage10 (
    .clk(clk), .reset(reset), .en(c6_tc), .up_dn(1'b1), .clr(1'b0), .load(1'b0),
    .load_val(4'd0),
`ifdef MODN_COUNTER_PRESCALE_EN
    .presc_div(4'd0),
`endif
    .count(c10_count), .tc(c10_tc), .wrap(c10_wrap), .load_err(c10_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0; load_val = 3'd0;
    en8 = 1'b0; up8 = 1'b1; c6_en = 1'b0;
`ifdef MODN_COUNTER_PRESCALE_EN
    presc_div = 4'd0;
`endif
    #10;
    checks++; if (count !== 3'd0) begin failures++; $display("[TB] FAIL reset_count actual=%0d required=0", count); end
    checks++; if (wrap !== 1'b0) begin failures++; $display("[TB] FAIL reset_wrap actual=%b required=0", wrap); end
    checks++; if (load_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_load_err actual=%b required=0", load_err); end
    checks++; if (tc !== 1'b0) begin failures++; $display("[TB] FAIL reset_tc actual=%b required=0", tc); end
    reset = 1'b0;
  endtask

  task automatic test_count_up();
    logic [2:0] exp_seq [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 7; i++) begin
      checks++; if (count !== exp_seq[i]) begin failures++; $display("[TB] FAIL up_count[%0d] actual=%0d required=%0d", i, count, exp_seq[i]); end
      checks++; if (tc !== (exp_seq[i] == 3'd5)) begin failures++; $display("[TB] FAIL up_tc[%0d] actual=%b required=%b", i, tc, exp_seq[i] == 3'd5); end
      checks++; if (wrap !== (i == 6)) begin failures++; $display("[TB] FAIL up_wrap[%0d] actual=%b required=%b", i, wrap, i == 6); end
      if (i < 6) tick();
    end
    tick();
    tick();
    checks++; if (count !== 3'd2) begin failures++; $display("[TB] FAIL up_to_two actual=%0d required=2", count); end
  endtask

  task automatic test_count_down();
    logic [2:0] exp_seq [4] = '{3'd1, 3'd0, 3'd5, 3'd4};
    up_dn = 1'b0;
    #1;
    checks++; if (tc !== 1'b0) begin failures++; $display("[TB] FAIL down_tc_start actual=%b required=0", tc); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (count !== exp_seq[i]) begin failures++; $display("[TB] FAIL down_count[%0d] actual=%0d required=%0d", i, count, exp_seq[i]); end
      checks++; if (tc !== (i == 1)) begin failures++; $display("[TB] FAIL down_tc[%0d] actual=%b required=%b", i, tc, i == 1); end
      checks++; if (wrap !== (i == 2)) begin failures++; $display("[TB] FAIL down_wrap[%0d] actual=%b required=%b", i, wrap, i == 2); end
    end
  endtask

  task automatic test_load();
    en = 1'b1; up_dn = 1'b1; load = 1'b1; load_val = 3'd5;
    tick();
    checks++; if (count !== 3'd5) begin failures++; $display("[TB] FAIL load_last actual=%0d required=5", count); end
    checks++; if (load_err !== 1'b0) begin failures++; $display("[TB] FAIL load_last_err actual=%b required=0", load_err); end
    load_val = 3'd7;
    #1;
    checks++; if (tc !== 1'b0) begin failures++; $display("[TB] FAIL load_masks_tc actual=%b required=0", tc); end
    tick();
    checks++; if (count !== 3'd5) begin failures++; $display("[TB] FAIL load_clamp actual=%0d required=5", count); end
    checks++; if (load_err !== 1'b1) begin failures++; $display("[TB] FAIL load_clamp_err actual=%b required=1", load_err); end
    checks++; if (wrap !== 1'b0) begin failures++; $display("[TB] FAIL load_clamp_wrap actual=%b required=0", wrap); end
    load_val = 3'd3;
    tick();
    checks++; if (count !== 3'd3) begin failures++; $display("[TB] FAIL load_three actual=%0d required=3", count); end
    checks++; if (load_err !== 1'b0) begin failures++; $display("[TB] FAIL load_three_err actual=%b required=0", load_err); end
    load_val = 3'd6;
    tick();
    checks++; if (count !== 3'd5) begin failures++; $display("[TB] FAIL load_six actual=%0d required=5", count); end
    checks++; if (load_err !== 1'b1) begin failures++; $display("[TB] FAIL load_six_err actual=%b required=1", load_err); end
    load = 1'b0; en = 1'b0;
    tick();
    checks++; if (load_err !== 1'b0) begin failures++; $display("[TB] FAIL load_err_pulse actual=%b required=0", load_err); end
    checks++; if (count !== 3'd5) begin failures++; $display("[TB] FAIL load_hold actual=%0d required=5", count); end
  endtask

  task automatic test_clear();
    load = 1'b1; load_val = 3'd4;
    tick();
    checks++; if (count !== 3'd4) begin failures++; $display("[TB] FAIL clr_setup actual=%0d required=4", count); end
    clr = 1'b1; load = 1'b1; load_val = 3'd2; en = 1'b1; up_dn = 1'b1;
    tick();
    checks++; if (count !== 3'd0) begin failures++; $display("[TB] FAIL clr_over_load actual=%0d required=0", count); end
    checks++; if (load_err !== 1'b0 || wrap !== 1'b0) begin failures++; $display("[TB] FAIL clr_pulses actual=%b%b required=00", load_err, wrap); end
    clr = 1'b0; load = 1'b0; en = 1'b0; up_dn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (tc !== 1'b0) begin failures++; $display("[TB] FAIL hold_tc[%0d] actual=%b required=0", i, tc); end
      tick();
      checks++; if (count !== 3'd0) begin failures++; $display("[TB] FAIL hold_count[%0d] actual=%0d required=0", i, count); end
    end
  endtask

  task automatic test_reset_midcount();
    en = 1'b1; up_dn = 1'b1;
    tick(); tick(); tick();
    checks++; if (count !== 3'd3) begin failures++; $display("[TB] FAIL mid_setup actual=%0d required=3", count); end
    #2 reset = 1'b1;
    #1;
    checks++; if (count !== 3'd0) begin failures++; $display("[TB] FAIL mid_async_reset actual=%0d required=0", count); end
    #1 reset = 1'b0;
    tick();
    checks++; if (count !== 3'd1) begin failures++; $display("[TB] FAIL mid_resume1 actual=%0d required=1", count); end
    tick();
    checks++; if (count !== 3'd2) begin failures++; $display("[TB] FAIL mid_resume2 actual=%0d required=2", count); end
    en = 1'b0;
  endtask

  task automatic test_full_range();
    en8 = 1'b1; up8 = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    checks++; if (count8 !== 3'd7 || tc8 !== 1'b1) begin failures++; $display("[TB] FAIL mod8_top actual=%0d/%b required=7/1", count8, tc8); end
    tick();
    checks++; if (count8 !== 3'd0 || wrap8 !== 1'b1) begin failures++; $display("[TB] FAIL mod8_wrap_up actual=%0d/%b required=0/1", count8, wrap8); end
    up8 = 1'b0;
    #1;
    checks++; if (tc8 !== 1'b1) begin failures++; $display("[TB] FAIL mod8_tc_down actual=%b required=1", tc8); end
    tick();
    checks++; if (count8 !== 3'd7 || wrap8 !== 1'b1) begin failures++; $display("[TB] FAIL mod8_wrap_down actual=%0d/%b required=7/1", count8, wrap8); end
    en8 = 1'b0;
    tick();
    checks++; if (wrap8 !== 1'b0 || load_err8 !== 1'b0) begin failures++; $display("[TB] FAIL mod8_pulse_end actual=%b%b required=00", wrap8, load_err8); end
  endtask

  task automatic test_cascade();
    int wraps = 0;
    checks++; if (c6_count !== 3'd0 || c10_count !== 4'd0) begin failures++; $display("[TB] FAIL chain_start actual=%0d/%0d required=0/0", c6_count, c10_count); end
    c6_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (c10_wrap === 1'b1) wraps++;
      if (i == 5) begin
        checks++; if (c10_count !== 4'd1) begin failures++; $display("[TB] FAIL chain_carry actual=%0d required=1", c10_count); end
      end
    end
    c6_en = 1'b0;
    checks++; if (c6_count !== 3'd0 || c10_count !== 4'd0) begin failures++; $display("[TB] FAIL chain_end actual=%0d/%0d required=0/0", c6_count, c10_count); end
    checks++; if (wraps != 1) begin failures++; $display("[TB] FAIL chain_wraps actual=%0d required=1", wraps); end
    checks++; if (c6_err !== 1'b0 || c10_err !== 1'b0 || c10_tc !== 1'b0) begin failures++; $display("[TB] FAIL chain_flags actual=%b%b%b required=000", c6_err, c10_err, c10_tc); end
  endtask

`ifdef MODN_COUNTER_PRESCALE_EN
  task automatic test_prescale();
    clr = 1'b1;
    tick();
    clr = 1'b0; presc_div = 4'd2; en = 1'b1; up_dn = 1'b1;
    for (int t = 1; t <= 9; t++) begin
      tick();
      checks++; if (count !== 3'(t / 3)) begin failures++; $display("[TB] FAIL presc_count[%0d] actual=%0d required=%0d", t, count, t / 3); end
    end
    en = 1'b0; presc_div = 4'd0;
  endtask
`endif

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_clear();
    test_reset_midcount();
    test_full_range();
    test_cascade();
`ifdef MODN_COUNTER_PRESCALE_EN
    test_prescale();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
